jogador_automatico: RTL and testbench

JOGADOR_AUTOMATICO -- requirements
Module: jogador_automatico

---
 rtl/jogo_pkg.sv | 45 ++++
 rtl/contador_tempo.sv | 37 +++
 rtl/jogador_automatico.sv | 180 ++++++++++++++++++
 tb/tb_jogador_automatico.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogo_pkg.sv
// Shared definitions for the automatic player: state encodings, default timings
// and the small LFSR / one-hot helpers used to invent new moves.
package jogo_pkg;

    typedef enum logic [3:0] {
        StInicial       = 4'd0,
        StInicia        = 4'd1,
        StEsperaMostra  = 4'd2,
        StPressiona     = 4'd3,
        StSolta         = 4'd4,
        StNovaPressiona = 4'd5,
        StNovaSolta     = 4'd6,
        StFimGanhou     = 4'd7,
        StFimPerdeu     = 4'd8,
        StErro          = 4'd9
    } estado_e;

    localparam int unsigned TempoIniciarDef   = 10;
    localparam int unsigned TempoPressionaDef = 10;
    localparam int unsigned TempoEsperaDef    = 10;
    localparam int unsigned TempoMostraDef    = 2000;

    localparam logic [3:0] LfsrSeed  = 4'b1001;
    localparam logic [3:0] RodadaMax = 4'd15;

    // x^4 + x^3 + 1, shifting towards the MSB
    function automatic logic [3:0] lfsr_next(input logic [3:0] l);
        return {l[2:0], l[3] ^ l[2]};
    endfunction

    function automatic logic [3:0] one_hot2(input logic [1:0] s);
        return 4'b0001 << s;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// Per-state cycle timer: cleared on entry, counts while enabled and saturates
// once the selected limit is reached.
module contador_tempo #(
    parameter int unsigned Width = 11
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [Width-1:0] limite_i,
    output logic [Width-1:0] cnt_o,
    output logic             fim_o
);

    logic [Width-1:0] cnt_d, cnt_q;

    assign fim_o = (cnt_q == limite_i - Width'(1));
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !fim_o) begin
            cnt_d = cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: starts a match, replays the growing
// sequence on the buttons and appends a pseudo-random move every round.
module jogador_automatico
    import jogo_pkg::*;
#(
    parameter int unsigned TEMPO_INICIAR   = TempoIniciarDef,
    parameter int unsigned TEMPO_PRESSIONA = TempoPressionaDef,
    parameter int unsigned TEMPO_ESPERA    = TempoEsperaDef,
    parameter int unsigned TEMPO_MOSTRA    = TempoMostraDef
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       habilitar,
    input  logic [3:0] leds,
    input  logic       ganhou,
    input  logic       perdeu,
    output logic       iniciar,
    output logic [3:0] botoes,
    output logic       fim_ganhou,
    output logic       fim_perdeu,
    output logic       erro,
    output logic [3:0] db_rodada,
    output logic [3:0] db_jogada,
    output logic [3:0] db_estado
);

    localparam int unsigned TempoMax =
        max4(TEMPO_INICIAR, TEMPO_PRESSIONA, TEMPO_ESPERA, TEMPO_MOSTRA);
    localparam int unsigned TimerW = $clog2(TempoMax + 1);

    estado_e           estado_d, estado_q;
    logic [3:0]        rodada_d, rodada_q;
    logic [3:0]        jogada_d, jogada_q;
    logic [3:0]        botoes_d, botoes_q;
    logic              iniciar_q, fim_ganhou_q, fim_perdeu_q, erro_q;
    logic [3:0]        lfsr_q;
    logic [3:0]        seq_q [16];
    logic              seq_we;
    logic [3:0]        seq_waddr, seq_wdata;
    logic [3:0]        nova;
    logic [TimerW-1:0] limite, tempo;
    logic              tempo_fim, tempo_clr, tempo_en, ativo;

    assign nova  = one_hot2(lfsr_q[1:0]);
    assign ativo = estado_q inside {StInicia, StEsperaMostra, StPressiona, StSolta,
                                    StNovaPressiona, StNovaSolta};

    always_comb begin
        unique case (estado_q)
            StInicia:                     limite = TimerW'(TEMPO_INICIAR);
            StEsperaMostra:               limite = TimerW'(TEMPO_MOSTRA);
            StPressiona, StNovaPressiona: limite = TimerW'(TEMPO_PRESSIONA);
            default:                      limite = TimerW'(TEMPO_ESPERA);
        endcase
    end

    assign tempo_clr = (estado_d != estado_q);
    assign tempo_en  = ativo;

    contador_tempo #(
        .Width(TimerW)
    ) u_contador_tempo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .clr_i   (tempo_clr),
        .en_i    (tempo_en),
        .limite_i(limite),
        .cnt_o   (tempo),
        .fim_o   (tempo_fim)
    );

    always_comb begin
        estado_d  = estado_q;
        rodada_d  = rodada_q;
        jogada_d  = jogada_q;
        botoes_d  = botoes_q;
        seq_we    = 1'b0;
        seq_waddr = rodada_q + 4'd1;
        seq_wdata = nova;
        unique case (estado_q)
            StInicial: begin
                if (habilitar) begin
                    estado_d = StInicia;
                    rodada_d = '0;
                    jogada_d = '0;
                end
            end
            StInicia: begin
                if (tempo_fim) estado_d = StEsperaMostra;
            end
            StEsperaMostra: begin
                if (leds != 4'd0) begin
                    estado_d  = StPressiona;
                    rodada_d  = '0;
                    jogada_d  = '0;
                    botoes_d  = leds;
                    seq_we    = 1'b1;
                    seq_waddr = '0;
                    seq_wdata = leds;
                end else if (tempo == TimerW'(TEMPO_MOSTRA - 1)) begin
                    // timeout read straight off the count
                    estado_d = StErro;
                end
            end
            StPressiona, StNovaPressiona: begin
                if (tempo_fim) begin
                    estado_d = (estado_q == StPressiona) ? StSolta : StNovaSolta;
                    botoes_d = '0;
                end
            end
            StSolta: begin
                if (tempo_fim) begin
                    if (jogada_q < rodada_q) begin
                        jogada_d = jogada_q + 4'd1;
                        estado_d = StPressiona;
                        botoes_d = seq_q[jogada_q + 4'd1];
                    end else if (rodada_q != RodadaMax) begin
                        estado_d = StNovaPressiona;
                        botoes_d = nova;
                        seq_we   = 1'b1;
                    end
                end
            end
            StNovaSolta: begin
                if (tempo_fim) begin
                    rodada_d = rodada_q + 4'd1;
                    jogada_d = '0;
                    estado_d = StPressiona;
                    botoes_d = seq_q[0];
                end
            end
            StFimGanhou, StFimPerdeu, StErro: begin
                if (!habilitar) estado_d = StInicial;
            end
            default: estado_d = StInicial;
        endcase

        // game outcome overrides every timed decision; a loss beats a win
        if (ativo && (perdeu || ganhou)) begin
            estado_d = perdeu ? StFimPerdeu : StFimGanhou;
            botoes_d = '0;
            seq_we   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q     <= StInicial;
            rodada_q     <= '0;
            jogada_q     <= '0;
            botoes_q     <= '0;
            iniciar_q    <= 1'b0;
            fim_ganhou_q <= 1'b0;
            fim_perdeu_q <= 1'b0;
            erro_q       <= 1'b0;
            lfsr_q       <= LfsrSeed;
        end else begin
            estado_q     <= estado_d;
            rodada_q     <= rodada_d;
            jogada_q     <= jogada_d;
            botoes_q     <= botoes_d;
            iniciar_q    <= (estado_d == StInicia);
            fim_ganhou_q <= (estado_d == StFimGanhou);
            fim_perdeu_q <= (estado_d == StFimPerdeu);
            erro_q       <= (estado_d == StErro);
            lfsr_q       <= lfsr_next(lfsr_q);
            if (seq_we) seq_q[seq_waddr] <= seq_wdata;
        end
    end

    assign iniciar    = iniciar_q;
    assign botoes     = botoes_q;
    assign fim_ganhou = fim_ganhou_q;
    assign fim_perdeu = fim_perdeu_q;
    assign erro       = erro_q;
    assign db_rodada  = rodada_q;
    assign db_jogada  = jogada_q;
    assign db_estado  = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a game model queues every expected button press
// (value and start cycle) when the first LED is shown; a monitor pops and checks them.
module tb_jogador_automatico;

    localparam logic [3:0] EInicial    = 4'd0;
    localparam logic [3:0] EEspera     = 4'd2;
    localparam logic [3:0] ESolta      = 4'd4;
    localparam logic [3:0] ENova       = 4'd5;
    localparam logic [3:0] EFimGanhou  = 4'd7;
    localparam logic [3:0] EFimPerdeu  = 4'd8;
    localparam logic [3:0] EErro       = 4'd9;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       habilitar = 1'b0;
    logic       ganhou = 1'b0;
    logic       perdeu = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       iniciar, fim_ganhou, fim_perdeu, erro;
    logic [3:0] botoes, db_rodada, db_jogada, db_estado;

    always #5 clock = ~clock;

    jogador_automatico dut (
        .clock     (clock),
        .reset     (reset),
        .habilitar (habilitar),
        .leds      (leds),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .iniciar   (iniciar),
        .botoes    (botoes),
        .fim_ganhou(fim_ganhou),
        .fim_perdeu(fim_perdeu),
        .erro      (erro),
        .db_rodada (db_rodada),
        .db_jogada (db_jogada),
        .db_estado (db_estado)
    );

    typedef struct {
        logic [3:0] val;
        int         edge_n;
    } press_t;

    press_t     exp_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_press = 0;
    bit         chk_len = 1'b1;
    logic [3:0] nova_obs = 4'd0;
    logic [3:0] first_nova = 4'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Non-reset edges since the last reset; edge n sees LFSR state step^n(seed).
    always @(posedge clock) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    function automatic logic [3:0] lfsr_at(input int n);
        logic [3:0] l;
        l = 4'b1001;
        for (int i = 0; i < n; i++) l = {l[2:0], l[3] ^ l[2]};
        return l;
    endfunction

    initial begin
        press_t     p;
        logic [3:0] prev_b;
        int         len;
        prev_b = 4'd0;
        len    = 0;
        forever begin
            @(negedge clock);
            if (prev_b == 4'd0 && botoes != 4'd0) begin
                if (exp_q.size() == 0) begin
                    check_eq("press_unexpected", 32'(botoes), 32'd0);
                end else begin
                    p = exp_q.pop_front();
                    check_eq("press_val", 32'(botoes), 32'(p.val));
                    check_eq("press_start", 32'(cyc), 32'(p.edge_n + 1));
                end
                if (n_press == 1) nova_obs = botoes;
                n_press++;
                len = 1;
            end else if (prev_b != 4'd0 && botoes != 4'd0) begin
                if (botoes != prev_b) check_eq("press_stable", 32'(botoes), 32'(prev_b));
                len++;
            end else if (prev_b != 4'd0 && botoes == 4'd0) begin
                if (chk_len) check_eq("press_len", 32'(len), 32'd10);
            end
            prev_b = botoes;
        end
    end

    task automatic restart();
        reset     = 1'b0;
        habilitar = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        leds      = 4'd0;
        repeat (3) @(negedge clock);
        exp_q.delete();
        n_press   = 0;
        chk_len   = 1'b1;
        reset     = 1'b1;
        habilitar = 1'b1;
    endtask

    // Drives the first LED 50 cycles after enabling and queues the whole 16-round game.
    task automatic play_game(input logic [3:0] led0);
        int         ni;
        int         k;
        int         n_l;
        logic [3:0] mseq [16];
        logic [3:0] l;
        press_t     p;
        ni = 0;
        k  = 0;
        while (cyc < 50) begin
            @(negedge clock);
            if (iniciar) ni++;
        end
        check_eq("iniciar_len", 32'(ni), 32'd10);
        leds    = led0;
        n_l     = cyc;
        mseq[0] = led0;
        for (int r = 0; r < 16; r++) begin
            for (int j = 0; j <= r; j++) begin
                p.val    = mseq[j];
                p.edge_n = n_l + 20 * k;
                exp_q.push_back(p);
                k++;
            end
            if (r < 15) begin
                l           = lfsr_at(n_l + 20 * k);
                mseq[r + 1] = 4'b0001 << l[1:0];
                p.val       = mseq[r + 1];
                p.edge_n    = n_l + 20 * k;
                exp_q.push_back(p);
                k++;
            end
        end
        @(negedge clock);
        leds = 4'd0;
    endtask

    initial begin
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_eq("rst_iniciar", 32'(iniciar), 32'd0);
        check_eq("rst_botoes", 32'(botoes), 32'd0);
        check_eq("rst_fim_ganhou", 32'(fim_ganhou), 32'd0);
        check_eq("rst_fim_perdeu", 32'(fim_perdeu), 32'd0);
        check_eq("rst_erro", 32'(erro), 32'd0);
        check_eq("rst_rodada", 32'(db_rodada), 32'd0);
        check_eq("rst_jogada", 32'(db_jogada), 32'd0);
        check_eq("rst_estado", 32'(db_estado), 32'(EInicial));

        // Full game to round 15, then a win
        restart();
        play_game(4'b0001);
        while (cyc < 71) @(negedge clock);
        check_eq("a_nova_estado", 32'(db_estado), 32'(ENova));
        check_eq("a_nova_onehot", 32'($onehot(botoes)), 32'd1);
        for (int i = 0; i < 3300 && !(n_press == 151 && botoes == 4'd0); i++)
            @(negedge clock);
        check_eq("a_presses", 32'(n_press), 32'd151);
        check_eq("a_queue_left", 32'(exp_q.size()), 32'd0);
        first_nova = nova_obs;
        repeat (20) @(negedge clock);
        check_eq("a_wait_estado", 32'(db_estado), 32'(ESolta));
        check_eq("a_wait_rodada", 32'(db_rodada), 32'd15);
        check_eq("a_wait_jogada", 32'(db_jogada), 32'd15);
        check_eq("a_wait_botoes", 32'(botoes), 32'd0);
        ganhou = 1'b1;
        @(negedge clock);
        check_eq("a_fim_ganhou", 32'(fim_ganhou), 32'd1);
        check_eq("a_ganhou_estado", 32'(db_estado), 32'(EFimGanhou));
        ganhou = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("a_ganhou_held", 32'(fim_ganhou), 32'd1);
        check_eq("a_ganhou_rodada", 32'(db_rodada), 32'd15);
        habilitar = 1'b0;
        @(negedge clock);
        check_eq("a_back_inicial", 32'(db_estado), 32'(EInicial));
        check_eq("a_flag_clear", 32'(fim_ganhou), 32'd0);

        // Loss in the middle of a press
        restart();
        play_game(4'b0100);
        while (cyc < 95) @(negedge clock);
        check_eq("b_pressing", 32'(botoes), 32'b0100);
        chk_len = 1'b0;
        perdeu  = 1'b1;
        @(negedge clock);
        check_eq("b_release", 32'(botoes), 32'd0);
        check_eq("b_fim_perdeu", 32'(fim_perdeu), 32'd1);
        check_eq("b_estado", 32'(db_estado), 32'(EFimPerdeu));
        perdeu = 1'b0;
        repeat (5) @(negedge clock);
        check_eq("b_held", 32'(fim_perdeu), 32'd1);
        check_eq("b_held_botoes", 32'(botoes), 32'd0);

        // Win and loss together during start-up
        restart();
        repeat (3) @(negedge clock);
        ganhou = 1'b1;
        perdeu = 1'b1;
        @(negedge clock);
        check_eq("c_fim_perdeu", 32'(fim_perdeu), 32'd1);
        check_eq("c_fim_ganhou", 32'(fim_ganhou), 32'd0);
        check_eq("c_iniciar", 32'(iniciar), 32'd0);
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        habilitar = 1'b0;
        @(negedge clock);
        check_eq("c_inicial", 32'(db_estado), 32'(EInicial));

        // No LED ever shown: timeout boundary
        restart();
        while (cyc < 2010) @(negedge clock);
        check_eq("e_before_erro", 32'(erro), 32'd0);
        check_eq("e_before_estado", 32'(db_estado), 32'(EEspera));
        @(negedge clock);
        check_eq("e_erro", 32'(erro), 32'd1);
        check_eq("e_botoes", 32'(botoes), 32'd0);
        check_eq("e_estado", 32'(db_estado), 32'(EErro));

        // Reset during round 5, then replay from scratch
        restart();
        play_game(4'b0010);
        while (cyc < 455) @(negedge clock);
        check_eq("d_rodada", 32'(db_rodada), 32'd5);
        check_eq("d_pressing", 32'(botoes), 32'b0010);
        chk_len = 1'b0;
        reset   = 1'b0;
        @(negedge clock);
        check_eq("d_rst_botoes", 32'(botoes), 32'd0);
        check_eq("d_rst_rodada", 32'(db_rodada), 32'd0);
        check_eq("d_rst_jogada", 32'(db_jogada), 32'd0);
        check_eq("d_rst_estado", 32'(db_estado), 32'(EInicial));
        check_eq("d_rst_iniciar", 32'(iniciar), 32'd0);
        restart();
        play_game(4'b0001);
        while (cyc < 120 && n_press < 2) @(negedge clock);
        check_eq("d_presses", 32'(n_press >= 2), 32'd1);
        check_eq("d_reseed_nova", 32'(nova_obs), 32'(first_nova));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
